// File: rtl/seg_scan_decoder.sv
// Decodes a multiplexed 4-digit 7-segment scan back into symbol codes.
// Commits one frame per full scan and extracts bulls/cows from "nAmb" frames.
module seg_scan_decoder #(
  parameter int SETTLE_CYCLES = 2,
  parameter int TIMEOUT       = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] DIGIT,
  input  logic [6:0] DISPLAY,
  output logic [3:0] dig0,
  output logic [3:0] dig1,
  output logic [3:0] dig2,
  output logic [3:0] dig3,
  output logic       frame_valid,
  output logic       result_valid,
  output logic [2:0] bulls,
  output logic [2:0] cows,
  output logic       scan_lost
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE_CYCLES);
  localparam logic [SW-1:0] SETTLE_HIT = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TMO_MAX    = TW'(TIMEOUT);

  typedef enum logic [1:0] {HUNT = 2'd0, COLLECT = 2'd1, LOST = 2'd2} state_t;

  logic [3:0]    digit_s1_q, digit_s2_q, digit_prev_q;
  logic [6:0]    disp_s1_q, disp_s2_q, disp_prev_q;
  logic [SW-1:0] stable_q, stable_d;
  logic [TW-1:0] tmo_q, tmo_d;
  state_t        state_q;
  logic [3:0]    mask_q, mask_d;
  logic [3:0]    shadow_q [4];
  logic [3:0]    frame_d [4];
  logic [3:0]    dig_q [4];
  logic          frame_valid_q, result_valid_q, scan_lost_q;
  logic [2:0]    bulls_q, cows_q;
  logic          pos_ok, capture, is_result;
  logic [1:0]    pos;
  logic [3:0]    code;

  always_comb begin
    pos    = 2'd0;
    pos_ok = 1'b0;
    case (digit_s2_q)
      4'b1110: begin pos = 2'd0; pos_ok = 1'b1; end
      4'b1101: begin pos = 2'd1; pos_ok = 1'b1; end
      4'b1011: begin pos = 2'd2; pos_ok = 1'b1; end
      4'b0111: begin pos = 2'd3; pos_ok = 1'b1; end
      default: begin pos = 2'd0; pos_ok = 1'b0; end
    endcase
  end

  always_comb begin
    case (disp_s2_q)
      7'b1000000: code = 4'd0;
      7'b1111001: code = 4'd1;
      7'b0100100: code = 4'd2;
      7'b0110000: code = 4'd3;
      7'b0011001: code = 4'd4;
      7'b0010010: code = 4'd5;
      7'b0000010: code = 4'd6;
      7'b1111000: code = 4'd7;
      7'b0000000: code = 4'd8;
      7'b0010000: code = 4'd9;
      7'b0001000: code = 4'd10;
      7'b0000011: code = 4'd11;
      7'b0111111: code = 4'd12;
      default:    code = 4'd15;
    endcase
  end

  // Stable count saturates one past the hit value, so a long dwell captures only once.
  always_comb begin
    stable_d = stable_q;
    if (digit_s2_q != digit_prev_q || disp_s2_q != disp_prev_q) begin
      stable_d = '0;
    end else if (stable_q != SETTLE_MAX) begin
      stable_d = stable_q + 1'b1;
    end
    capture = pos_ok && (stable_d == SETTLE_HIT);
    if (capture) begin
      tmo_d = '0;
    end else if (tmo_q == TMO_MAX) begin
      tmo_d = tmo_q;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end
    mask_d = (pos == 2'd0) ? 4'b0001 : (mask_q | (4'b0001 << pos));
    for (int i = 0; i < 4; i++) begin
      frame_d[i] = (capture && pos == 2'(i)) ? code : shadow_q[i];
    end
    is_result = (frame_d[2] == 4'd10) && (frame_d[0] == 4'd11) &&
                (frame_d[3] <= 4'd4) && (frame_d[1] <= 4'd4);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_s1_q     <= 4'hF;
      digit_s2_q     <= 4'hF;
      digit_prev_q   <= 4'hF;
      disp_s1_q      <= 7'h7F;
      disp_s2_q      <= 7'h7F;
      disp_prev_q    <= 7'h7F;
      stable_q       <= '0;
      tmo_q          <= '0;
      state_q        <= HUNT;
      mask_q         <= '0;
      frame_valid_q  <= 1'b0;
      result_valid_q <= 1'b0;
      scan_lost_q    <= 1'b0;
      bulls_q        <= '0;
      cows_q         <= '0;
      for (int i = 0; i < 4; i++) begin
        shadow_q[i] <= 4'hF;
        dig_q[i]    <= 4'hF;
      end
    end else begin
      digit_s1_q    <= DIGIT;
      digit_s2_q    <= digit_s1_q;
      digit_prev_q  <= digit_s2_q;
      disp_s1_q     <= DISPLAY;
      disp_s2_q     <= disp_s1_q;
      disp_prev_q   <= disp_s2_q;
      stable_q      <= stable_d;
      tmo_q         <= tmo_d;
      frame_valid_q <= 1'b0;
      case (state_q)
        HUNT, LOST: begin
          if (capture && pos == 2'd0) begin
            shadow_q[0] <= code;
            mask_q      <= 4'b0001;
            state_q     <= COLLECT;
          end else if (state_q == HUNT && tmo_d == TMO_MAX) begin
            state_q     <= LOST;
            mask_q      <= '0;
            scan_lost_q <= 1'b1;
          end
        end
        COLLECT: begin
          if (capture) begin
            if (mask_d == 4'b1111) begin
              for (int i = 0; i < 4; i++) dig_q[i] <= frame_d[i];
              frame_valid_q  <= 1'b1;
              scan_lost_q    <= 1'b0;
              mask_q         <= '0;
              state_q        <= HUNT;
              result_valid_q <= is_result;
              if (is_result) begin
                bulls_q <= frame_d[3][2:0];
                cows_q  <= frame_d[1][2:0];
              end
            end else begin
              shadow_q[pos] <= code;
              mask_q        <= mask_d;
            end
          end else if (tmo_d == TMO_MAX) begin
            state_q     <= LOST;
            mask_q      <= '0;
            scan_lost_q <= 1'b1;
          end
        end
        default: state_q <= HUNT;
      endcase
    end
  end

  assign dig0         = dig_q[0];
  assign dig1         = dig_q[1];
  assign dig2         = dig_q[2];
  assign dig3         = dig_q[3];
  assign frame_valid  = frame_valid_q;
  assign result_valid = result_valid_q;
  assign bulls        = bulls_q;
  assign cows         = cows_q;
  assign scan_lost    = scan_lost_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench: the model works from the pin history (sample = pins two
// edges back, capture = run of identical samples reaching exactly SETTLE long).
module tb_seg_scan_decoder;
  localparam int SETTLE = 2;
  localparam int TMO    = 64;
  localparam int MAXE   = 60000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] DIGIT = 4'hF;
  logic [6:0] DISPLAY = 7'h7F;
  logic [3:0] dig0, dig1, dig2, dig3;
  logic       frame_valid, result_valid, scan_lost;
  logic [2:0] bulls, cows;

  seg_scan_decoder #(.SETTLE_CYCLES(SETTLE), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .DIGIT(DIGIT), .DISPLAY(DISPLAY),
    .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3),
    .frame_valid(frame_valid), .result_valid(result_valid),
    .bulls(bulls), .cows(cows), .scan_lost(scan_lost)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [13] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b0111111};
  logic [3:0] pos_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  int n_pass = 0, n_total = 0;
  int fv_cnt = 0, lost_at_fv = -1;
  int ecnt, last_set;
  logic [10:0] hist [MAXE];
  int m_dig [4], m_sh [4];
  int m_have, m_lost, m_fv, m_rv, m_b, m_c, last_cap;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
  endtask

  function automatic int decode(input logic [6:0] s);
    for (int i = 0; i < 13; i++) if (s == seg_tab[i]) return i;
    return 15;
  endfunction

  function automatic int posof(input logic [3:0] d);
    for (int i = 0; i < 4; i++) if (d == pos_tab[i]) return i;
    return -1;
  endfunction

  function automatic logic [6:0] seg(input int c);
    if (c < 13) return seg_tab[c];
    return 7'h7F;
  endfunction

  function automatic logic [10:0] sample(input int e);
    if (e < 3) return 11'h7FF;
    return hist[e-2];
  endfunction

  task automatic model_reset();
    ecnt = 0; last_cap = 0;
    m_have = 0; m_lost = 0; m_fv = 0; m_rv = 0; m_b = 0; m_c = 0;
    for (int i = 0; i < 4; i++) begin m_dig[i] = 15; m_sh[i] = 15; end
  endtask

  task automatic model_step();
    logic [10:0] s;
    int n, p, cd;
    ecnt++;
    if (ecnt < MAXE) hist[ecnt] = {DIGIT, DISPLAY};
    m_fv = 0;
    s = sample(ecnt);
    n = 1;
    while (n <= SETTLE && sample(ecnt - n) == s) n++;
    p = posof(s[10:7]);
    cd = decode(s[6:0]);
    if (n == SETTLE && p >= 0) begin
      last_cap = ecnt;
      if (p == 0) begin
        m_have = 1; m_sh[0] = cd;
      end else if (m_have != 0) begin
        m_sh[p] = cd;
        m_have = m_have | (1 << p);
        if (m_have == 15) begin
          for (int i = 0; i < 4; i++) m_dig[i] = m_sh[i];
          m_fv = 1; m_lost = 0; m_have = 0;
          if (m_sh[2] == 10 && m_sh[0] == 11 && m_sh[3] <= 4 && m_sh[1] <= 4) begin
            m_rv = 1; m_b = m_sh[3] & 7; m_c = m_sh[1] & 7;
          end else m_rv = 0;
        end
      end
    end else if ((m_have != 0 || m_lost == 0) && ecnt - last_cap >= TMO) begin
      m_lost = 1; m_have = 0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  // Per-cycle compare of the whole output bundle against the model.
  initial begin
    logic [24:0] act;
    int expv;
    forever begin
      @(negedge clk);
      act  = {dig3, dig2, dig1, dig0, frame_valid, result_valid, bulls, cows, scan_lost};
      expv = (m_dig[3] << 21) | (m_dig[2] << 17) | (m_dig[1] << 13) | (m_dig[0] << 9) |
             (m_fv << 8) | (m_rv << 7) | (m_b << 4) | (m_c << 1) | m_lost;
      chk("cycle", int'(act), expv);
      if (frame_valid) begin fv_cnt++; lost_at_fv = int'(scan_lost); end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic dwell(input logic [3:0] d, input logic [6:0] s, input int n);
    @(negedge clk);
    DIGIT = d; DISPLAY = s; last_set = ecnt;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic scan(input int c3, input int c2, input int c1, input int c0, input int n);
    dwell(pos_tab[0], seg(c0), n);
    dwell(pos_tab[1], seg(c1), n);
    dwell(pos_tab[2], seg(c2), n);
    dwell(pos_tab[3], seg(c3), n);
  endtask

  task automatic idle(input int n);
    dwell(4'hF, 7'h7F, n);
  endtask

  initial begin
    int fv0, t3, r;
    int cs [4];
    repeat (3) @(negedge clk);
    chk("rst_dig0", int'(dig0), 15);
    chk("rst_dig3", int'(dig3), 15);
    chk("rst_flags", int'({frame_valid, result_valid, scan_lost}), 0);
    #2 rst = 1'b0;

    scan(1, 10, 2, 11, 4);
    scan(1, 10, 2, 11, 4);
    idle(3);
    chk("t1_fv_count", fv_cnt, 2);
    chk("t1_digs", int'({dig3, dig2, dig1, dig0}), 'h1A2B);
    chk("t1_result", int'({result_valid, bulls, cows}), 'b1_001_010);

    scan(12, 12, 12, 12, 4);
    idle(3);
    chk("t2_digs", int'({dig3, dig2, dig1, dig0}), 'hCCCC);
    chk("t2_result_held", int'({result_valid, bulls, cows}), 'b0_001_010);

    dwell(pos_tab[0], seg(11), 4);
    dwell(pos_tab[1], seg(2), 4);
    dwell(pos_tab[2], seg(10), 2);
    dwell(pos_tab[2], seg(8), 1);
    dwell(pos_tab[2], seg(10), 2);
    dwell(pos_tab[3], seg(1), 4);
    idle(3);
    chk("t3_dig2_glitch", int'(dig2), 10);

    fv0 = fv_cnt;
    dwell(pos_tab[0], seg(5), 4);
    dwell(4'b1100, seg(3), 4);
    dwell(pos_tab[1], 7'h7F, 4);
    dwell(pos_tab[2], seg(6), 4);
    dwell(pos_tab[3], seg(7), 4);
    idle(3);
    chk("t4_fv", fv_cnt - fv0, 1);
    chk("t4_digs", int'({dig3, dig2, dig1, dig0}), 'h76F5);

    dwell(pos_tab[0], seg(11), 4);
    dwell(pos_tab[1], seg(0), 4);
    dwell(pos_tab[2], seg(10), 4);
    dwell(pos_tab[3], seg(3), 4);
    t3 = last_set;
    @(negedge clk);
    DIGIT = 4'hF; DISPLAY = 7'h7F;
    while (ecnt < t3 + 4 + TMO - 1) @(negedge clk);
    chk("t5_lost_before", int'(scan_lost), 0);
    @(negedge clk);
    chk("t5_lost_at_64", int'(scan_lost), 1);
    chk("t5_dig_hold", int'({dig3, dig2, dig1, dig0}), 'h3A0B);
    chk("t5_result", int'({result_valid, bulls, cows}), 'b1_011_000);
    idle(10);
    fv0 = fv_cnt;
    scan(4, 10, 4, 11, 4);
    idle(3);
    chk("t5_resume_fv", fv_cnt - fv0, 1);
    chk("t5_lost_at_fv", lost_at_fv, 0);

    dwell(pos_tab[0], seg(1), 4);
    dwell(pos_tab[1], seg(2), 4);
    dwell(pos_tab[2], seg(3), 2);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_digs", int'({dig3, dig2, dig1, dig0}), 'hFFFF);
    chk("t6_rst_flags", int'({frame_valid, result_valid, bulls, cows, scan_lost}), 0);
    DIGIT = 4'hF; DISPLAY = 7'h7F;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    fv0 = fv_cnt;
    dwell(pos_tab[1], seg(2), 4);
    dwell(pos_tab[2], seg(3), 4);
    dwell(pos_tab[3], seg(4), 4);
    idle(3);
    chk("t6_no_fv", fv_cnt - fv0, 0);
    scan(4, 3, 2, 1, 4);
    idle(3);
    chk("t6_fv_after_scan", fv_cnt - fv0, 1);
    chk("t6_digs", int'({dig3, dig2, dig1, dig0}), 'h4321);

    for (int it = 0; it < 250; it++) begin
      r = $urandom_range(0, 9);
      if (r < 4) begin
        for (int k = 0; k < 4; k++) cs[k] = $urandom_range(0, 15);
        for (int k = 0; k < 4; k++) dwell(pos_tab[k], seg(cs[k]), $urandom_range(1, 5));
      end else if (r < 6) begin
        cs[0] = 11; cs[1] = $urandom_range(0, 6); cs[2] = 10; cs[3] = $urandom_range(0, 6);
        for (int k = 0; k < 4; k++) dwell(pos_tab[k], seg(cs[k]), $urandom_range(2, 4));
      end else if (r == 6) begin
        dwell(4'($urandom), 7'($urandom), $urandom_range(1, 6));
      end else if (r == 7) begin
        idle($urandom_range(40, 90));
      end else begin
        dwell(pos_tab[$urandom_range(0, 3)], seg($urandom_range(0, 12)), $urandom_range(1, 5));
      end
    end
    idle(5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
